pixel_image_loader: RTL

- Writer side of the packed pixel-image bus that the pixel row multiplexer reads.
- Accepts a raster-order stream of pixels over a valid/ready handshake and deposits each pixel into a packed row-major image register.
- Raises Image_Valid once a full SEL_SIZE x (OUT_SIZE/PIXEL_BITS) frame has been written.
- Holds the frame stable until the consumer releases it.

---
 rtl/pixel_pkg.sv | 15 +
 rtl/pixel_raster_counter.sv | 52 +++++
 rtl/pixel_image_loader.sv | 128 ++++++++++++
 3 files changed

// File: rtl/pixel_pkg.sv
// Shared constants and state encoding for the pixel image loader and row multiplexer.
package pixel_pkg;

    localparam int DEF_OUT_SIZE   = 280;
    localparam int DEF_SEL_SIZE   = 28;
    localparam int DEF_SEL_BIT    = 5;
    localparam int DEF_PIXEL_BITS = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2
    } loader_state_t;

endpackage

// File: rtl/pixel_raster_counter.sv
// Raster-order column/row counter pair with enable, synchronous clear and last-pixel flag.
module pixel_raster_counter #(
    parameter int COLS     = 28,
    parameter int ROWS     = 28,
    parameter int CNT_BITS = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                enable,
    output logic [CNT_BITS-1:0] row_count,
    output logic [CNT_BITS-1:0] col_count,
    output logic                last
);

    localparam logic [CNT_BITS-1:0] COL_MAX = CNT_BITS'(COLS - 1);
    localparam logic [CNT_BITS-1:0] ROW_MAX = CNT_BITS'(ROWS - 1);

    logic [CNT_BITS-1:0] row_reg, row_next;
    logic [CNT_BITS-1:0] col_reg, col_next;

    always_comb begin
        row_next = row_reg;
        col_next = col_reg;
        if (clear) begin
            row_next = '0;
            col_next = '0;
        end else if (enable) begin
            if (col_reg == COL_MAX) begin
                col_next = '0;
                row_next = (row_reg == ROW_MAX) ? '0 : row_reg + 1'b1;
            end else begin
                col_next = col_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_reg <= '0;
            col_reg <= '0;
        end else begin
            row_reg <= row_next;
            col_reg <= col_next;
        end
    end

    assign row_count = row_reg;
    assign col_count = col_reg;
    assign last      = (row_reg == ROW_MAX) && (col_reg == COL_MAX);

endmodule

// File: rtl/pixel_image_loader.sv
// Streams raster-order pixels into a packed row-major image and holds it until released.
// Define PIXEL_IMAGE_LOADER_CLEAR_EN to zero the whole image on every entry into LOAD.
module pixel_image_loader
    import pixel_pkg::*;
#(
    parameter int OUT_SIZE   = DEF_OUT_SIZE,
    parameter int SEL_SIZE   = DEF_SEL_SIZE,
    parameter int SEL_BIT    = DEF_SEL_BIT,
    parameter int PIXEL_BITS = DEF_PIXEL_BITS
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         Start,
    input  logic [PIXEL_BITS-1:0]        Pixel_In,
    input  logic                         Pixel_Valid,
    output logic                         Pixel_Ready,
    output logic [OUT_SIZE*SEL_SIZE-1:0] Image_Out,
    output logic                         Image_Valid,
    input  logic                         Image_Release,
    output logic [SEL_BIT-1:0]           Row_Count,
    output logic [SEL_BIT-1:0]           Col_Count,
    output logic                         Busy
);

    localparam int COLS   = OUT_SIZE / PIXEL_BITS;
    localparam int PIXELS = SEL_SIZE * COLS;

    loader_state_t state_reg, state_next;

    logic               transfer;
    logic               load_entry;
    logic               last_pixel;
    logic               frame_clear;
    logic [SEL_BIT-1:0] row_count;
    logic [SEL_BIT-1:0] col_count;

    assign transfer = Pixel_Valid && (state_reg == LOAD);

    always_comb begin
        state_next = state_reg;
        load_entry = 1'b0;
        case (state_reg)
            IDLE: begin
                if (Start) begin
                    state_next = LOAD;
                    load_entry = 1'b1;
                end
            end
            LOAD: begin
                if (transfer && last_pixel) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                if (Image_Release) begin
                    if (Start) begin
                        state_next = LOAD;
                        load_entry = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    pixel_raster_counter #(
        .COLS     (COLS),
        .ROWS     (SEL_SIZE),
        .CNT_BITS (SEL_BIT)
    ) u_counter (
        .clk       (Clk),
        .rst       (Reset),
        .clear     (load_entry),
        .enable    (transfer),
        .row_count (row_count),
        .col_count (col_count),
        .last      (last_pixel)
    );

`ifdef PIXEL_IMAGE_LOADER_CLEAR_EN
    assign frame_clear = load_entry;
`else
    assign frame_clear = 1'b0;
`endif

    // Pixel index gi maps to offset gi*PIXEL_BITS because OUT_SIZE == COLS*PIXEL_BITS.
    logic [PIXEL_BITS-1:0] pix_reg [PIXELS];

    genvar gi;
    generate
        for (gi = 0; gi < PIXELS; gi++) begin : g_pixel
            localparam logic [SEL_BIT-1:0] PIX_ROW = SEL_BIT'(gi / COLS);
            localparam logic [SEL_BIT-1:0] PIX_COL = SEL_BIT'(gi % COLS);

            logic hit;
            assign hit = transfer && (row_count == PIX_ROW) && (col_count == PIX_COL);

            always_ff @(posedge Clk or posedge Reset) begin
                if (Reset) begin
                    pix_reg[gi] <= '0;
                end else if (frame_clear) begin
                    pix_reg[gi] <= '0;
                end else if (hit) begin
                    pix_reg[gi] <= Pixel_In;
                end
            end

            assign Image_Out[gi*PIXEL_BITS +: PIXEL_BITS] = pix_reg[gi];
        end
    endgenerate

    assign Pixel_Ready = (state_reg == LOAD);
    assign Busy        = (state_reg == LOAD);
    assign Image_Valid = (state_reg == FULL);
    assign Row_Count   = row_count;
    assign Col_Count   = col_count;

endmodule
